// File: rtl/add64_seq_ctrl_if.sv
// Operand/result handshake bundle for add64_seq_ctrl.
// The slave modport is the sequencer; the master modport is whoever feeds operands and drains results.
interface add64_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        c_out;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/add64_seq_ctrl.sv
// Operand sequencer and result capture around a 64-bit ripple-carry adder (rca64).
// Optional macro ADD64_OVFL_EN adds a registered signed-overflow output ovfl.
module rca64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic [63:0] sum,
    output logic        c_out
);
    logic carry;

    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end
endmodule

module add64_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    add64_seq_ctrl_if.slave    bus,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
`ifdef ADD64_OVFL_EN
    ,
    output logic               ovfl
`endif
);
    // A zero setting still needs one settle cycle before capture.
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic        c_in_q;
    logic [63:0] rca_sum;
    logic        rca_c_out;

    rca64 u_rca64 (
        .a     (a_q),
        .b     (b_q),
        .c_in  (c_in_q),
        .sum   (rca_sum),
        .c_out (rca_c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            c_in_q        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.c_out     <= 1'b0;
            busy          <= 1'b0;
            op_count      <= '0;
`ifdef ADD64_OVFL_EN
            ovfl          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.a;
                        b_q          <= bus.b;
                        c_in_q       <= bus.c_in;
                        cnt          <= 4'(SETTLE_EFF - 1);
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        bus.sum       <= rca_sum;
                        bus.c_out     <= rca_c_out;
`ifdef ADD64_OVFL_EN
                        ovfl          <= (a_q[63] == b_q[63]) && (rca_sum[63] != a_q[63]);
`endif
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        op_count      <= op_count + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Directed, table-driven bench for add64_seq_ctrl with hand-written multi-cycle sequences.
module tb_add64_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] op_count;
`ifdef ADD64_OVFL_EN
    logic        ovfl;
`endif

    add64_seq_ctrl_if bus ();

    add64_seq_ctrl #(
        .SETTLE_CYCLES (4),
        .CNT_W         (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
`ifdef ADD64_OVFL_EN
        ,
        .ovfl     (ovfl)
`endif
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        c_in;
        logic [63:0] exp_sum;
        logic        exp_c_out;
        logic        exp_ovfl;
    } vec_t;

    vec_t vecs [7];
    int   n_pass;
    int   n_total;
    int   exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c_in);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = c_in;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("hs_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("hs_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("hs_op_count", {48'd0, op_count}, 64'(exp_cnt));
    endtask

    task automatic run_vec(input int i);
        int lat;
        send(vecs[i].a, vecs[i].b, vecs[i].c_in);
        chk("settle_busy", {63'd0, busy}, 64'd1);
        wait_valid(lat);
        chk("latency", 64'(lat), 64'd4);
        chk("sum", bus.sum, vecs[i].exp_sum);
        chk("c_out", {63'd0, bus.c_out}, {63'd0, vecs[i].exp_c_out});
`ifdef ADD64_OVFL_EN
        chk("ovfl", {63'd0, ovfl}, {63'd0, vecs[i].exp_ovfl});
`endif
        handshake();
    endtask

    initial begin
        int  lat;
        int  k;
        logic seen;

        n_pass = 0; n_total = 0; exp_cnt = 0;
        vecs[0] = '{64'd1, 64'd1, 1'b1, 64'd3, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd1, 1'b1, 1'b0};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};
        vecs[5] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0};
        vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_sum", bus.sum, 64'd0);
        chk("rst_op_count", {48'd0, op_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // out_ready with nothing pending must not count
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_ready_op_count", {48'd0, op_count}, 64'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Backpressure with an ignored in_valid during the stall
        send(vecs[2].a, vecs[2].b, vecs[2].c_in);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        bus.in_valid = 1'b1; bus.a = 64'd5; bus.b = 64'd5; bus.c_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_sum", bus.sum, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("bp_c_out", {63'd0, bus.c_out}, 64'd0);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        bus.in_valid = 1'b0;
        handshake();
        @(negedge clk);
        chk("bp_no_stray_accept", {63'd0, busy}, 64'd0);

        // Back-to-back with operands changing during SETTLE
        bus.out_ready = 1'b1;
        send(64'hF, 64'hF, 1'b0);
        bus.in_valid = 1'b1; bus.a = 64'hFFFF_FFFF; bus.b = 64'hBA; bus.c_in = 1'b1;
        k = 0; seen = 1'b0;
        while (k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                chk("b2b_sum0", bus.sum, 64'h1E);
            end
            if (bus.in_ready) break;
        end
        chk("b2b_first_seen", {63'd0, seen}, 64'd1);
        chk("b2b_spacing", 64'(k + 1), 64'd6);
        exp_cnt++;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        wait_valid(lat);
        chk("b2b_latency", 64'(lat), 64'd4);
        chk("b2b_sum1", bus.sum, 64'h1_0000_00BA);
        chk("b2b_c_out1", {63'd0, bus.c_out}, 64'd0);
        handshake();
        chk("b2b_op_count", {48'd0, op_count}, 64'd10);

        // Reset in the middle of SETTLE
        send(64'd1, 64'd2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_sum", bus.sum, 64'd0);
        chk("mid_rst_op_count", {48'd0, op_count}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", {63'd0, seen}, 64'd0);
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
